// File: rtl/index_mask_decoder_pkg.sv
// useful_pkg: shared state type for the index mask decoder
package useful_pkg;
  typedef enum logic {ACCUM, HOLD} idx_dec_state_t;
endpackage

// File: rtl/index_mask_decoder_onehot.sv
// onehot_decoder: binary index to one-hot vector, flags indices beyond the mask width
module onehot_decoder #(
  parameter int MASKWIDTH = 16,
  localparam int INDEXWIDTH = $clog2(MASKWIDTH)
) (
  input  logic [INDEXWIDTH-1:0] index,
  output logic [MASKWIDTH-1:0]  onehot,
  output logic                  out_of_range
);
  for (genvar g = 0; g < MASKWIDTH; g++) begin : g_bit
    assign onehot[g] = index == INDEXWIDTH'(g);
  end
  assign out_of_range = {1'b0, index} >= (INDEXWIDTH+1)'(MASKWIDTH);
endmodule

// File: rtl/index_mask_decoder.sv
// index_mask_decoder: ORs a stream of decoded indices into a mask and hands it out per packet
module index_mask_decoder
  import useful_pkg::*;
#(
  parameter int MASKWIDTH = 16,
  localparam int INDEXWIDTH = $clog2(MASKWIDTH),
  localparam int COUNTWIDTH = $clog2(MASKWIDTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INDEXWIDTH-1:0] in_index,
  input  logic                  in_null,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MASKWIDTH-1:0]  out_mask,
  output logic [COUNTWIDTH-1:0] out_count,
  output logic                  out_dup,
  output logic                  out_range
);
  idx_dec_state_t state, state_nx;
  logic [MASKWIDTH-1:0] onehot, mask_base, mask_nx;
  logic [COUNTWIDTH-1:0] count_base, count_nx;
  logic oor, accept, hs, hit, seen, dup_nx, range_nx;
  onehot_decoder #(.MASKWIDTH(MASKWIDTH)) u_dec (.index(in_index), .onehot(onehot), .out_of_range(oor));
  assign out_valid = state == HOLD;
  assign in_ready  = out_valid ? out_ready : 1'b1;
  // a handshake retires the held mask, so any same-cycle beat starts from zero
  always_comb begin
    accept     = in_valid & in_ready;
    hs         = out_valid & out_ready;
    mask_base  = hs ? '0 : out_mask;
    count_base = hs ? '0 : out_count;
    hit        = accept & ~in_null & ~oor;
    seen       = |(mask_base & onehot);
    mask_nx    = hit ? (mask_base | onehot) : mask_base;
    count_nx   = count_base + COUNTWIDTH'(hit & ~seen);
    dup_nx     = (hs ? 1'b0 : out_dup) | (hit & seen);
    range_nx   = (hs ? 1'b0 : out_range) | (accept & ~in_null & oor);
    state_nx   = (accept & in_last) ? HOLD : hs ? ACCUM : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      out_mask  <= '0;
      out_count <= '0;
      out_dup   <= 1'b0;
      out_range <= 1'b0;
    end else begin
      state     <= state_nx;
      out_mask  <= mask_nx;
      out_count <= count_nx;
      out_dup   <= dup_nx;
      out_range <= range_nx;
    end
  end
endmodule

// File: tb/tb_index_mask_decoder.sv
// tb_index_mask_decoder: scoreboard bench over a 16-wide and a 10-wide decoder fed the same stream
module tb_index_mask_decoder;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_null = 0, in_last = 0, out_ready = 0;
  logic [3:0] in_index = 0;
  logic rdy16, rdy10, val16, val10, dup16, dup10, rng16, rng10;
  logic [15:0] mask16;
  logic [9:0] mask10;
  logic [4:0] cnt16;
  logic [3:0] cnt10;
  int checks = 0, failures = 0;

  typedef struct {
    logic [15:0] m16; int c16; logic d16, r16;
    logic [9:0] m10; int c10; logic d10, r10;
  } exp_t;
  exp_t q[$];
  logic [15:0] acc16;
  logic [9:0] acc10;
  logic ad16, ar16, ad10, ar10;
  logic hold_m;

  always #5 clk = ~clk;

  index_mask_decoder #(.MASKWIDTH(16)) d16 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
    .in_index(in_index), .in_null(in_null), .in_last(in_last), .out_valid(val16), .out_ready(out_ready),
    .out_mask(mask16), .out_count(cnt16), .out_dup(dup16), .out_range(rng16));
  index_mask_decoder #(.MASKWIDTH(10)) d10 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy10),
    .in_index(in_index), .in_null(in_null), .in_last(in_last), .out_valid(val10), .out_ready(out_ready),
    .out_mask(mask10), .out_count(cnt10), .out_dup(dup10), .out_range(rng10));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: packet = set of indices; flags from set membership and width bound
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      acc16 = 0; acc10 = 0; ad16 = 0; ar16 = 0; ad10 = 0; ar10 = 0; hold_m = 0;
    end else begin
      automatic bit acc = in_valid && (!hold_m || out_ready);
      automatic int idx = int'(in_index);
      if (hold_m && out_ready) hold_m = 0;
      if (acc) begin
        if (!in_null) begin
          if (acc16[idx]) ad16 = 1; else acc16[idx] = 1;
          if (idx >= 10) ar10 = 1;
          else if (acc10[idx]) ad10 = 1;
          else acc10[idx] = 1;
        end
        if (in_last) begin
          q.push_back('{acc16, $countones(acc16), ad16, ar16, acc10, $countones(acc10), ad10, ar10});
          acc16 = 0; acc10 = 0; ad16 = 0; ar16 = 0; ad10 = 0; ar10 = 0;
          hold_m = 1;
        end
      end
    end
  end

  // monitor: retire one expected mask per output handshake
  always @(posedge clk) begin
    if (!rst && val16 && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        automatic exp_t e = q.pop_front();
        chk("mask16", 32'(mask16), 32'(e.m16));
        chk("count16", 32'(cnt16), 32'(e.c16));
        chk("dup16", 32'(dup16), 32'(e.d16));
        chk("range16", 32'(rng16), 32'(e.r16));
        chk("mask10", 32'(mask10), 32'(e.m10));
        chk("count10", 32'(cnt10), 32'(e.c10));
        chk("dup10", 32'(dup10), 32'(e.d10));
        chk("range10", 32'(rng10), 32'(e.r10));
      end
    end
  end

  // handshake levels and stability of the held mask, checked mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid16", 32'(val16), 32'(hold_m));
      chk("out_valid10", 32'(val10), 32'(hold_m));
      chk("in_ready16", 32'(rdy16), 32'(!hold_m || out_ready));
      chk("in_ready10", 32'(rdy10), 32'(!hold_m || out_ready));
      if (hold_m && q.size() != 0) begin
        chk("hold_mask16", 32'(mask16), 32'(q[0].m16));
        chk("hold_count16", 32'(cnt16), 32'(q[0].c16));
        chk("hold_mask10", 32'(mask10), 32'(q[0].m10));
      end
    end
  end

  task automatic drive(input bit v, input int idx, input bit nul, input bit last, input bit ordy);
    @(posedge clk); #1;
    in_valid = v; in_index = 4'(idx); in_null = nul; in_last = last; out_ready = ordy;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mask16", 32'(mask16), 0);
    chk("rst_count16", 32'(cnt16), 0);
    chk("rst_flags16", 32'({dup16, rng16}), 0);
    chk("rst_mask10", 32'(mask10), 0);
    drive(1, 3, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 15, 0, 1, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    drive(1, 7, 0, 1, 1);
    drive(1, 5, 0, 0, 1);
    drive(1, 5, 0, 1, 1);
    drive(1, 12, 0, 0, 1);
    drive(1, 2, 0, 1, 1);
    drive(1, 0, 1, 0, 1);
    drive(1, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1);
    drive(1, 4, 0, 0, 1);
    drive(1, 5, 0, 0, 1);
    drive(1, 6, 0, 0, 1);
    drive(1, 7, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_mask16", 32'(mask16), 32'h00F0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_rst_valid", 32'(val16), 0);
    chk("post_rst_mask16", 32'(mask16), 0);
    chk("post_rst_ready", 32'(rdy16), 1);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(3) != 0, int'($urandom_range(15)), $urandom_range(7) == 0,
            $urandom_range(3) == 0, $urandom_range(1) == 1);
    for (int i = 0; i < 20 && hold_m; i++) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("drain_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
